// File: rtl/picobello_uart_tx.sv
// Byte-oriented UART transmitter with an input FIFO and a programmable baud divisor.
// Frames are 8 data bits LSB first, optional even parity, one or two stop bits.
module picobello_uart_tx #(
   parameter int unsigned FifoDepth = 8,
   parameter int unsigned DivWidth  = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [DivWidth-1:0]              clk_div_i,
   input  logic                             parity_en_i,
   input  logic                             stop2_i,
   input  logic                             flush_i,
   input  logic [7:0]                       data_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   output logic                             tx_o,
   output logic                             busy_o,
   output logic [$clog2(FifoDepth+1)-1:0]   fifo_usage_o
);
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = $clog2(FifoDepth+1);
   localparam int unsigned CW   = DivWidth + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   logic [7:0]          mem [FifoDepth];
   logic [PtrW-1:0]     wptr;
   logic [PtrW-1:0]     rptr;
   logic [CntW-1:0]     count;
   logic                full;
   logic                push;
   logic                pop;

   state_e              state;
   logic [7:0]          shift;
   logic [DivWidth-1:0] div;
   logic                par_en;
   logic                stop2;
   logic                par_bit;
   logic [CW-1:0]       cnt;
   logic [2:0]          bit_idx;
   logic                bit_done;
   logic [DivWidth-1:0] div_in;
   logic [CW-1:0]       bit_len;
   logic [CW-1:0]       stop_len;
   logic [CW-1:0]       load_len;

   assign full         = (count == CntW'(FifoDepth));
   assign ready_o      = !full;
   assign push         = valid_i && !full && !flush_i;
   assign bit_done     = (cnt == '0);
   // A flush also cancels a pop in the same cycle, so the cleared entries never reach the line.
   assign pop          = (count != '0) && !flush_i &&
                         ((state == IDLE) || ((state == STOP) && bit_done));
   assign busy_o       = (state != IDLE) || (count != '0);
   assign fifo_usage_o = count;

   assign div_in   = (clk_div_i == '0) ? DivWidth'(1) : clk_div_i;
   assign bit_len  = {1'b0, div} - CW'(1);
   assign stop_len = stop2 ? ({div, 1'b0} - CW'(1)) : bit_len;
   assign load_len = {1'b0, div_in} - CW'(1);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush_i) begin
         rptr  <= wptr;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PtrW'(1);
         if (pop)  rptr <= rptr + PtrW'(1);
         count <= count + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         tx_o    <= 1'b1;
         shift   <= '0;
         div     <= DivWidth'(1);
         par_en  <= 1'b0;
         stop2   <= 1'b0;
         par_bit <= 1'b0;
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         if ((state != IDLE) && !bit_done) begin
            cnt <= cnt - CW'(1);
         end
         // Frame configuration is sampled only when a byte leaves the FIFO.
         if (pop) begin
            shift   <= mem[rptr];
            par_bit <= ^mem[rptr];
            div     <= div_in;
            par_en  <= parity_en_i;
            stop2   <= stop2_i;
            cnt     <= load_len;
            tx_o    <= 1'b0;
            state   <= START;
         end else begin
            case (state)
               IDLE: begin
                  tx_o <= 1'b1;
               end
               START: begin
                  if (bit_done) begin
                     state   <= DATA;
                     bit_idx <= '0;
                     tx_o    <= shift[0];
                     cnt     <= bit_len;
                  end
               end
               DATA: begin
                  if (bit_done) begin
                     shift <= shift >> 1;
                     if (bit_idx == 3'd7) begin
                        if (par_en) begin
                           state <= PARITY;
                           tx_o  <= par_bit;
                           cnt   <= bit_len;
                        end else begin
                           state <= STOP;
                           tx_o  <= 1'b1;
                           cnt   <= stop_len;
                        end
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx_o    <= shift[1];
                        cnt     <= bit_len;
                     end
                  end
               end
               PARITY: begin
                  if (bit_done) begin
                     state <= STOP;
                     tx_o  <= 1'b1;
                     cnt   <= stop_len;
                  end
               end
               STOP: begin
                  if (bit_done) begin
                     state <= IDLE;
                     tx_o  <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  tx_o  <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule
